// File: rtl/if_fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage (master) and memory (slave).
// A request is held with a stable address until the memory acknowledges it.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage with IF/ID register: owns the PC, issues variable-latency
// memory requests, and delivers instructions to decode under stall and branch redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] EX_MEM_NPC,
  if_fetch_unit_if.master imem,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_NPC,
  output logic        IF_ID_valid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] kill_tgt_q, kill_tgt_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = {EX_MEM_NPC[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;
  assign busy           = (state_q == S_REQ);
  assign IF_ID_instr    = instr_q;
  assign IF_ID_NPC      = npc_q;
  assign IF_ID_valid    = valid_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    kill_tgt_d = kill_tgt_q;
    hold_d     = hold_q;
    instr_d    = instr_q;
    npc_d      = npc_q;
    valid_d    = valid_q;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;

      S_REQ: begin
        if (imem.imem_ack) begin
          if (PCSrc) begin
            pc_d    = target;
            kill_d  = 1'b0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else if (kill_q) begin
            // Returning data belongs to the squashed path; redirect now.
            pc_d    = kill_tgt_q;
            kill_d  = 1'b0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            instr_d = imem.imem_rdata;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (PCSrc) begin
          // The bus request cannot be withdrawn, so remember the redirect until it completes.
          kill_d     = 1'b1;
          kill_tgt_d = target;
          instr_d    = NOP_INSTR;
          valid_d    = 1'b0;
        end else if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (PCSrc) begin
          pc_d    = target;
          state_d = S_REQ;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = hold_q;
          npc_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      kill_tgt_q <= '0;
      hold_q     <= '0;
      instr_q    <= NOP_INSTR;
      npc_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      kill_tgt_q <= kill_tgt_d;
      hold_q     <= hold_d;
      instr_q    <= instr_d;
      npc_q      <= npc_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed and random steps against a
// transaction-level fetch model, plus a PC wrap-around check on a second instance.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, pcsrc = 1'b0;
  logic [31:0] ex_npc = '0;
  logic [31:0] if_instr, if_npc;
  logic        if_valid, busy;

  logic        rst_w = 1'b1;
  logic        stall_w = 1'b0, pcsrc_w = 1'b0;
  logic [31:0] ex_npc_w = '0;
  logic [31:0] w_instr, w_npc;
  logic        w_valid, w_busy;

  if_fetch_unit_if imem_bus ();
  if_fetch_unit_if imem_w ();

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(pcsrc), .EX_MEM_NPC(ex_npc),
    .imem(imem_bus.master), .IF_ID_instr(if_instr), .IF_ID_NPC(if_npc),
    .IF_ID_valid(if_valid), .busy(busy)
  );

  if_fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst_w), .stall(stall_w), .PCSrc(pcsrc_w), .EX_MEM_NPC(ex_npc_w),
    .imem(imem_w.master), .IF_ID_instr(w_instr), .IF_ID_NPC(w_npc),
    .IF_ID_valid(w_valid), .busy(w_busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: fetch pointer, a queue of fetched-but-stalled words,
  // an optional pending redirect, and the word currently presented to decode.
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  bit          m_redirect_pending;
  logic [31:0] m_redirect_to;
  logic [31:0] m_instr, m_npc;
  bit          m_valid;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic present_bubble();
    m_instr = NOP;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_pc = 32'h0;
    m_held.delete();
    m_redirect_pending = 1'b0;
    m_redirect_to = '0;
    m_instr = NOP;
    m_npc = '0;
    m_valid = 1'b0;
  endtask

  // One clock of stimulus: drive at negedge, check request side, advance the
  // model, then check the decode side just after the rising edge.
  task automatic cycle(input bit r, input bit s, input bit p, input logic [31:0] t, input bit a);
    bit          m_req;
    logic [31:0] rd, tgt;
    @(negedge clk);
    m_req = m_started && (m_held.size() == 0);
    rd    = m_req ? tag(m_pc) : $urandom;
    rst = r; stall = s; pcsrc = p; ex_npc = t;
    imem_bus.imem_ack = a; imem_bus.imem_rdata = rd;
    chk("req", {31'b0, imem_bus.imem_req}, {31'b0, m_req});
    chk("busy", {31'b0, busy}, {31'b0, m_req});
    if (m_req) chk("addr", imem_bus.imem_addr, m_pc);

    tgt = t & 32'hFFFF_FFFC;
    if (r) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held.size() != 0) begin
      if (p) begin
        m_held.delete(); m_pc = tgt; present_bubble();
      end else if (!s) begin
        m_instr = m_held.pop_front(); m_npc = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end else if (a) begin
      if (p) begin
        m_pc = tgt; m_redirect_pending = 1'b0; present_bubble();
      end else if (m_redirect_pending) begin
        m_pc = m_redirect_to; m_redirect_pending = 1'b0; present_bubble();
      end else if (s) begin
        m_held.push_back(rd);
      end else begin
        m_instr = rd; m_npc = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end else if (p) begin
      m_redirect_pending = 1'b1; m_redirect_to = tgt; present_bubble();
    end else if (!s) begin
      present_bubble();
    end

    @(posedge clk);
    #1;
    chk("if_instr", if_instr, m_instr);
    chk("if_npc", if_npc, m_npc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    imem_w.imem_ack = 1'b0; imem_w.imem_rdata = '0;
    model_reset();

    // Reset and back-to-back single-cycle fetches.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    repeat (7) cycle(0, 0, 0, 0, 1);

    // Three-cycle latency: two bubbles between instructions.
    repeat (2) begin
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
    end

    // Stall catching an ack, held for four cycles, then released.
    cycle(0, 1, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);

    // Redirect while a request is pending, unaligned target.
    cycle(0, 0, 1, 32'h103, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Second redirect overwrites the saved one; redirect coinciding with the ack wins.
    cycle(0, 0, 1, 32'h200, 0);
    cycle(0, 1, 1, 32'h300, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h400, 0);
    cycle(0, 0, 1, 32'h500, 1);
    cycle(0, 0, 0, 0, 1);

    // Redirect while holding a stalled word; redirect with ack and no pending kill.
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 32'h600, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 1, 32'h700, 1);
    cycle(0, 0, 0, 0, 1);

    // Redirect near the top of memory so the PC wraps.
    cycle(0, 0, 1, 32'hFFFF_FFF9, 1);
    repeat (3) cycle(0, 0, 0, 0, 1);

    // Reset in the middle of a request, then late acks.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 10), $urandom, ($urandom_range(0, 99) < 50));
    end

    // Wrap-around on an instance reset to 32'hFFFF_FFF8 with an always-acking memory.
    @(negedge clk); rst_w = 1'b0; imem_w.imem_ack = 1'b1;
    chk("w_req_idle", {31'b0, imem_w.imem_req}, 32'h0);
    @(negedge clk);
    chk("w_addr0", imem_w.imem_addr, 32'hFFFF_FFF8);
    imem_w.imem_rdata = tag(32'hFFFF_FFF8);
    @(negedge clk);
    chk("w_addr1", imem_w.imem_addr, 32'hFFFF_FFFC);
    chk("w_instr0", w_instr, tag(32'hFFFF_FFF8));
    chk("w_npc0", w_npc, 32'hFFFF_FFFC);
    chk("w_valid0", {31'b0, w_valid}, 32'h1);
    imem_w.imem_rdata = tag(32'hFFFF_FFFC);
    @(negedge clk);
    chk("w_addr2", imem_w.imem_addr, 32'h0);
    chk("w_instr1", w_instr, tag(32'hFFFF_FFFC));
    chk("w_npc1", w_npc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
